jtag_cfg_reg_slave: RTL and testbench
=====================================

// Module: jtag_cfg_reg_slave
// PURPOSE
//  User-app slave on one jtag_hub port: exchanges a fixed-length DR frame with the host over the hub's broadcast
//  TCK/TDI/capture/shift bus and its own conf_sel bit. Decodes the frame into a write or read of a local 32-bit
//  config register bank, or a read of read-only status words. Drives the per-port hub_tdo return line.
// PARAMETERS
//  ADDR_W    6   address field width; FRAME_LEN = 1+ADDR_W+DATA_W (39 at defaults)
//  DATA_W    32  data field width
//  NUM_REGS  8   RW config registers at addresses 0..NUM_REGS-1 (NUM_REGS <= 2**(ADDR_W-1))
//  NUM_STAT  4   RO status words at addresses 2**(ADDR_W-1)+0..NUM_STAT-1 (0x20.. at defaults)
//  REG_INIT  0   reset value of every config register (DATA_W bits)
// PORTS
//  drck_in     in   1                 TCK_USER from hub; sole clock, all flops rise-edge
//  resetn_i    in   1                 async active-low reset
//  hub_tdi_i   in   1                 serial data from hub
//  capt_i      in   1                 capture-DR (hub capt_o)
//  shift_i     in   1                 shift-DR (hub shift_o, already 1-clk delayed)
//  sel_i       in   1                 this port's conf_sel bit
//  hub_tdo_o   out  1                 serial return to hub_tdo[n]
//  stat_i      in   NUM_STAT*DATA_W   RO status words, word k at [k*DATA_W +: DATA_W]
//  cfg_regs_o  out  NUM_REGS*DATA_W   config register contents, same packing
//  wr_stb_o    out  1                 1-cycle pulse on every committed register write
//  wr_addr_o   out  ADDR_W            address of last committed write
// BEHAVIOUR
//  Reset: FSM=IDLE, sr=0, cnt=0, err=0, last_addr=0, rdata=0, cfg_regs=REG_INIT, wr_stb_o=0, wr_addr_o=0.
//  Shift register sr[FRAME_LEN-1:0] serves both directions: shift -> sr <= {hub_tdi_i, sr[FRAME_LEN-1:1]}.
//  hub_tdo_o = sel_i ? sr[0] : 1'b0 (combinational; 0 when deselected, also during reset).
//  Inbound frame, LSB first: [0]=wr, [ADDR_W:1]=addr, [FRAME_LEN-1:ADDR_W+1]=wdata (ignored for reads).
//  Capture word, LSB first: [0]=err, [ADDR_W:1]=last_addr, [FRAME_LEN-1:ADDR_W+1]=rdata.
//  FSM IDLE/SHIFT/EXEC:
//   IDLE : sel_i&capt_i -> load sr=capture word, clear err, cnt=0 -> SHIFT. Else hold.
//   SHIFT: sel_i&capt_i -> reload as in IDLE (restart; capture wins). sel_i&shift_i -> shift, cnt++ saturating
//          at FRAME_LEN+1. !shift_i or !sel_i -> cnt==FRAME_LEN ? EXEC : (err=1 if cnt!=0, IDLE).
//          cnt==0 (capture with no shift) is not an error.
//   EXEC : single cycle, then IDLE. last_addr<=addr. Write: addr<NUM_REGS -> reg[addr]<=wdata, wr_stb_o=1
//          next cycle, wr_addr_o<=addr; else err=1, no write. Read: addr<NUM_REGS -> rdata<=reg[addr];
//          stat window hit -> rdata<=stat_i word (sampled this cycle); else rdata<=0, err=1.
//  Read latency: data returned in capture word of the next DR scan; a read and its result need two scans.
//  err sticky across scans until reported by a capture; cleared only on capture.
//  Frames shorter/longer than FRAME_LEN: no register side effect, err=1.
//  stat_i treated as quasi-static/already in drck domain; no sync inside this block.
//  Async reset mid-frame: discard frame, outputs to reset values immediately.
// STRUCTURE
//  Shared package jtag_cfg_pkg: ADDR_W/DATA_W defaults, FRAME_LEN function, state enum (IDLE,SHIFT,EXEC),
//  frame field offsets (WR_BIT, ADDR_LSB, DATA_LSB), STAT_BASE.
//  One sub-module: jtag_cfg_reg_bank (reg array, write port, read mux incl. stat window, range check -> hit/err).
//  Top keeps FSM, sr, cnt, err, last_addr, rdata, strobe.
// TESTING
//  1 Write frame wr=1 addr=3 wdata=0xDEADBEEF (39 shifts, then shift low) -> cfg reg3=0xDEADBEEF, wr_stb_o
//    one pulse, wr_addr_o=3, other regs REG_INIT; next capture word err=0,last_addr=3.
//  2 Read addr=3 then second scan -> shifted-out bits [38:7]=0xDEADBEEF, [6:1]=3, [0]=0.
//  3 stat_i word1=0x12345678, read addr 0x21 -> next scan rdata=0x12345678; read 0x30 -> rdata=0, err=1.
//  4 Write addr=10 (>=NUM_REGS) -> no wr_stb_o, all regs unchanged, next capture err=1, following capture err=0.
//  5 38-bit and 40-bit frames -> no write, err=1; capture then 0 shifts -> err unchanged (0).
//  6 Deassert resetn_i after 20 shifts -> all outputs reset values, hub_tdo_o=0; sel_i=0 during shift ->
//    hub_tdo_o=0 and sr unchanged.

Source files
------------

// File: rtl/jtag_cfg_pkg.sv
// Shared definitions for the JTAG user-port config slave: defaults, FSM states, frame layout.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package jtag_cfg_pkg;

   localparam int ADDR_W_DEF = 6;
   localparam int DATA_W_DEF = 32;

   // Frame layout, LSB first on the wire: [WR_BIT] then address then data.
   localparam int WR_BIT   = 0;
   localparam int ADDR_LSB = 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_EXEC  = 2'd2
   } state_t;

   function automatic int frame_len(input int addr_w, input int data_w);
      return 1 + addr_w + data_w;
   endfunction

   // Bit position of the data field inside a frame.
   function automatic int data_lsb(input int addr_w);
      return ADDR_LSB + addr_w;
   endfunction

   // Status words live in the upper half of the address space.
   function automatic int stat_base(input int addr_w);
      return 1 << (addr_w - 1);
   endfunction

endpackage

// File: rtl/jtag_cfg_reg_bank.sv
// Config register array with write port, plus read mux covering RW registers and RO status window.
// Latency: writes land on the clock edge after wr_en; read data and hit flags are combinational.
// Backpressure: none; every access completes in the cycle it is presented.
//
// Ports:
//   clk, rst_n          clock and async active-low reset
//   wr_en               write request (ignored when addr is outside the register range)
//   addr, wdata         access address and write data
//   stat                flattened RO status words, word k at [k*DATA_W +: DATA_W]
//   cfg_regs            flattened register contents, same packing
//   rd_data             register or status word at addr, 0 when nothing decodes
//   reg_hit, stat_hit   addr falls in the RW register range / the RO status window
module jtag_cfg_reg_bank
   import jtag_cfg_pkg::*;
#(
   parameter int                ADDR_W   = ADDR_W_DEF,
   parameter int                DATA_W   = DATA_W_DEF,
   parameter int                NUM_REGS = 8,
   parameter int                NUM_STAT = 4,
   parameter logic [DATA_W-1:0] REG_INIT = '0
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         wr_en,
   input  logic [ADDR_W-1:0]            addr,
   input  logic [DATA_W-1:0]            wdata,
   input  logic [NUM_STAT*DATA_W-1:0]   stat,
   output logic [NUM_REGS*DATA_W-1:0]   cfg_regs,
   output logic [DATA_W-1:0]            rd_data,
   output logic                         reg_hit,
   output logic                         stat_hit
);

   localparam int STAT_BASE = stat_base(ADDR_W);

   logic [31:0] addr_u;

   assign addr_u   = 32'(addr);
   assign reg_hit  = (addr_u < 32'(NUM_REGS));
   assign stat_hit = (addr_u >= 32'(STAT_BASE)) && (addr_u < 32'(STAT_BASE + NUM_STAT));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            cfg_regs[i*DATA_W +: DATA_W] <= REG_INIT;
         end
      end else if (wr_en && reg_hit) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            if (addr_u == 32'(i)) begin
               cfg_regs[i*DATA_W +: DATA_W] <= wdata;
            end
         end
      end
   end

   // Decode by comparison rather than array indexing so the address width
   // never has to match the register count.
   always_comb begin
      rd_data = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (addr_u == 32'(i)) begin
            rd_data = cfg_regs[i*DATA_W +: DATA_W];
         end
      end
      for (int k = 0; k < NUM_STAT; k++) begin
         if (addr_u == 32'(STAT_BASE + k)) begin
            rd_data = stat[k*DATA_W +: DATA_W];
         end
      end
   end

endmodule

// File: rtl/jtag_cfg_reg_slave.sv
// JTAG hub user-port slave: one fixed-length DR frame per scan, decoded into a register write or read.
// Latency: access executes one TCK after shift ends; read data returns in the capture word of the next scan.
// Backpressure: none; the host paces everything through TCK and the capture/shift strobes.
//
// Ports:
//   drck_in                 TCK_USER from the hub, only clock
//   resetn_i                async active-low reset
//   hub_tdi_i, hub_tdo_o    serial data in from / out to the hub (tdo forced 0 when not selected)
//   capt_i, shift_i, sel_i  capture-DR, shift-DR and this port's select bit
//   stat_i                  RO status words, word k at [k*DATA_W +: DATA_W]
//   cfg_regs_o              config register contents, same packing
//   wr_stb_o, wr_addr_o     one-cycle pulse per committed write and the address it hit
module jtag_cfg_reg_slave
   import jtag_cfg_pkg::*;
#(
   parameter int                ADDR_W   = ADDR_W_DEF,
   parameter int                DATA_W   = DATA_W_DEF,
   parameter int                NUM_REGS = 8,
   parameter int                NUM_STAT = 4,
   parameter logic [DATA_W-1:0] REG_INIT = '0
) (
   input  logic                         drck_in,
   input  logic                         resetn_i,
   input  logic                         hub_tdi_i,
   input  logic                         capt_i,
   input  logic                         shift_i,
   input  logic                         sel_i,
   output logic                         hub_tdo_o,
   input  logic [NUM_STAT*DATA_W-1:0]   stat_i,
   output logic [NUM_REGS*DATA_W-1:0]   cfg_regs_o,
   output logic                         wr_stb_o,
   output logic [ADDR_W-1:0]            wr_addr_o
);

   localparam int FRAME_LEN = frame_len(ADDR_W, DATA_W);
   localparam int DATA_LSB  = data_lsb(ADDR_W);
   localparam int CNT_W     = $clog2(FRAME_LEN + 2);

   // Counter stops one past a full frame so over-long scans stay distinguishable.
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_LEN);
   localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_LEN + 1);

   state_t                state, state_nxt;
   logic [FRAME_LEN-1:0]  sr;
   logic [CNT_W-1:0]      cnt;
   logic                  err;
   logic [ADDR_W-1:0]     last_addr;
   logic [DATA_W-1:0]     rdata;

   logic                  load_cap;
   logic                  do_shift;
   logic                  bad_len;
   logic                  exec;

   logic                  fr_wr;
   logic [ADDR_W-1:0]     fr_addr;
   logic [DATA_W-1:0]     fr_wdata;
   logic [DATA_W-1:0]     bank_rdata;
   logic                  reg_hit;
   logic                  stat_hit;

   assign fr_wr     = sr[WR_BIT];
   assign fr_addr   = sr[ADDR_LSB +: ADDR_W];
   assign fr_wdata  = sr[DATA_LSB +: DATA_W];
   assign exec      = (state == ST_EXEC);
   assign hub_tdo_o = sel_i ? sr[0] : 1'b0;

   jtag_cfg_reg_bank #(
      .ADDR_W   (ADDR_W),
      .DATA_W   (DATA_W),
      .NUM_REGS (NUM_REGS),
      .NUM_STAT (NUM_STAT),
      .REG_INIT (REG_INIT)
   ) u_bank (
      .clk      (drck_in),
      .rst_n    (resetn_i),
      .wr_en    (exec && fr_wr),
      .addr     (fr_addr),
      .wdata    (fr_wdata),
      .stat     (stat_i),
      .cfg_regs (cfg_regs_o),
      .rd_data  (bank_rdata),
      .reg_hit  (reg_hit),
      .stat_hit (stat_hit)
   );

   always_ff @(posedge drck_in or negedge resetn_i) begin
      if (!resetn_i) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      load_cap  = 1'b0;
      do_shift  = 1'b0;
      bad_len   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (sel_i && capt_i) begin
               load_cap  = 1'b1;
               state_nxt = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            // A fresh capture restarts the frame even mid-shift.
            if (sel_i && capt_i) begin
               load_cap = 1'b1;
            end else if (sel_i && shift_i) begin
               do_shift = 1'b1;
            end else if (cnt == CNT_FULL) begin
               state_nxt = ST_EXEC;
            end else begin
               // Capture followed by no shifting at all is a legal status poll.
               bad_len   = (cnt != '0);
               state_nxt = ST_IDLE;
            end
         end
         ST_EXEC: begin
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge drck_in or negedge resetn_i) begin
      if (!resetn_i) begin
         sr        <= '0;
         cnt       <= '0;
         err       <= 1'b0;
         last_addr <= '0;
         rdata     <= '0;
         wr_stb_o  <= 1'b0;
         wr_addr_o <= '0;
      end else begin
         wr_stb_o <= 1'b0;

         if (load_cap) begin
            // err is reported in this word, so it is cleared as it is loaded.
            sr  <= {rdata, last_addr, err};
            err <= 1'b0;
            cnt <= '0;
         end else if (do_shift) begin
            sr <= {hub_tdi_i, sr[FRAME_LEN-1:1]};
            if (cnt != CNT_SAT) begin
               cnt <= cnt + 1'b1;
            end
         end

         if (bad_len) begin
            err <= 1'b1;
         end

         if (exec) begin
            last_addr <= fr_addr;
            if (fr_wr) begin
               if (reg_hit) begin
                  wr_stb_o  <= 1'b1;
                  wr_addr_o <= fr_addr;
               end else begin
                  err <= 1'b1;
               end
            end else begin
               rdata <= bank_rdata;
               if (!(reg_hit || stat_hit)) begin
                  err <= 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_jtag_cfg_reg_slave.sv
`timescale 1ns/1ps
module tb_jtag_cfg_reg_slave;

   localparam int AW = 6;
   localparam int DW = 32;
   localparam int NR = 8;
   localparam int NS = 4;
   localparam int FL = 1 + AW + DW;
   localparam int SB = 32;

   logic                drck_in;
   logic                resetn_i;
   logic                hub_tdi_i;
   logic                capt_i;
   logic                shift_i;
   logic                sel_i;
   logic                hub_tdo_o;
   logic [NS*DW-1:0]    stat_i;
   logic [NR*DW-1:0]    cfg_regs_o;
   logic                wr_stb_o;
   logic [AW-1:0]       wr_addr_o;

   jtag_cfg_reg_slave #(
      .ADDR_W   (AW),
      .DATA_W   (DW),
      .NUM_REGS (NR),
      .NUM_STAT (NS)
   ) dut (
      .drck_in    (drck_in),
      .resetn_i   (resetn_i),
      .hub_tdi_i  (hub_tdi_i),
      .capt_i     (capt_i),
      .shift_i    (shift_i),
      .sel_i      (sel_i),
      .hub_tdo_o  (hub_tdo_o),
      .stat_i     (stat_i),
      .cfg_regs_o (cfg_regs_o),
      .wr_stb_o   (wr_stb_o),
      .wr_addr_o  (wr_addr_o)
   );

   initial drck_in = 1'b0;
   always #5 drck_in = ~drck_in;

   typedef struct packed {
      logic [AW-1:0]    addr;
      logic [NR*DW-1:0] regs;
   } wr_exp_t;

   logic [FL-1:0] cap_q[$];
   wr_exp_t       wr_q[$];

   int checks = 0;
   int errors = 0;

   // Reference model state, updated per scan from the frame rules.
   logic [DW-1:0] m_regs [NR];
   logic          m_err;
   logic [AW-1:0] m_last;
   logic [DW-1:0] m_rdata;

   task automatic check(input string name, input logic [NR*DW-1:0] act, input logic [NR*DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [NR*DW-1:0] m_flat();
      logic [NR*DW-1:0] f;
      for (int i = 0; i < NR; i++) f[i*DW +: DW] = m_regs[i];
      return f;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NR; i++) m_regs[i] = '0;
      m_err   = 1'b0;
      m_last  = '0;
      m_rdata = '0;
   endtask

   // ---------------- monitor: collects shifted-out bits and write strobes ----------------
   logic [63:0] mon_bits;
   int          mon_n;
   bit          mon_act = 1'b0;
   wr_exp_t     mon_w;

   task automatic end_frame();
      logic [FL-1:0] e;
      logic [FL-1:0] mask;
      if (cap_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL capture_underflow: got a frame with %0d bits, expected no frame", mon_n);
         return;
      end
      e = cap_q.pop_front();
      if (mon_n > 0) begin
         mask = '0;
         for (int i = 0; i < FL && i < mon_n; i++) mask[i] = 1'b1;
         check("capture_word", mon_bits[FL-1:0] & mask, e & mask);
      end
   endtask

   always @(negedge drck_in) begin
      if (!resetn_i) begin
         if (mon_act) end_frame();
         mon_act = 1'b0;
      end else if (sel_i && capt_i) begin
         if (mon_act) end_frame();
         mon_act  = 1'b1;
         mon_n    = 0;
         mon_bits = '0;
      end else if (mon_act && sel_i && shift_i) begin
         if (mon_n < 64) mon_bits[mon_n] = hub_tdo_o;
         mon_n++;
      end else if (mon_act) begin
         end_frame();
         mon_act = 1'b0;
      end

      if (wr_stb_o) begin
         if (wr_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL wr_stb_unexpected: got strobe addr %0d, expected none", wr_addr_o);
         end else begin
            mon_w = wr_q.pop_front();
            check("wr_addr", NR*DW'(wr_addr_o), NR*DW'(mon_w.addr));
            check("regs_at_wr", cfg_regs_o, mon_w.regs);
         end
      end
   end

   // ---------------- driver + model ----------------
   task automatic model_scan(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                             input int nsh);
      int ai;
      ai = int'(addr);
      cap_q.push_back({m_rdata, m_last, m_err});
      m_err = 1'b0;
      if (nsh == FL) begin
         m_last = addr;
         if (wr) begin
            if (ai < NR) begin
               m_regs[ai] = wdata;
               wr_q.push_back({addr, m_flat()});
            end else begin
               m_err = 1'b1;
            end
         end else if (ai < NR) begin
            m_rdata = m_regs[ai];
         end else if (ai >= SB && ai < SB + NS) begin
            m_rdata = stat_i[(ai-SB)*DW +: DW];
         end else begin
            m_rdata = '0;
            m_err   = 1'b1;
         end
      end else if (nsh != 0) begin
         m_err = 1'b1;
      end
   endtask

   task automatic scan(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata, input int nsh);
      logic [63:0] fr;
      fr = {$urandom(), $urandom()};
      fr[FL-1:0] = {wdata, addr, wr};
      model_scan(wr, addr, wdata, nsh);
      @(posedge drck_in); #2;
      capt_i = 1'b1;
      @(posedge drck_in); #2;
      capt_i = 1'b0;
      for (int i = 0; i < nsh; i++) begin
         shift_i   = 1'b1;
         hub_tdi_i = fr[i];
         @(posedge drck_in); #2;
      end
      shift_i   = 1'b0;
      hub_tdi_i = 1'b0;
      repeat (4) @(posedge drck_in);
      #2;
      check("cfg_regs_after_scan", cfg_regs_o, m_flat());
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got simulation still running, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [FL-1:0] e;
      logic [AW-1:0] a;
      int            r;
      int            ns;

      resetn_i  = 1'b0;
      hub_tdi_i = 1'b0;
      capt_i    = 1'b0;
      shift_i   = 1'b0;
      sel_i     = 1'b1;
      for (int k = 0; k < NS; k++) stat_i[k*DW +: DW] = $urandom();
      stat_i[1*DW +: DW] = 32'h1234_5678;
      model_reset();

      #22;
      check("reset_tdo", NR*DW'(hub_tdo_o), '0);
      check("reset_wr_stb", NR*DW'(wr_stb_o), '0);
      check("reset_wr_addr", NR*DW'(wr_addr_o), '0);
      check("reset_cfg_regs", cfg_regs_o, '0);
      @(posedge drck_in); #2;
      resetn_i = 1'b1;

      // Directed: write, readback, status window, range errors, bad lengths.
      scan(1'b1, 6'd3,    32'hDEAD_BEEF, FL);
      scan(1'b0, 6'd3,    32'h0,         FL);
      scan(1'b0, 6'h21,   32'h0,         FL);
      scan(1'b0, 6'h30,   32'h0,         FL);
      scan(1'b1, 6'd10,   32'hCAFE_F00D, FL);
      scan(1'b0, 6'd0,    32'h0,         FL);
      scan(1'b0, 6'd0,    32'h0,         FL);
      scan(1'b1, 6'd1,    32'h1111_1111, FL - 1);
      scan(1'b1, 6'd2,    32'h2222_2222, FL + 1);
      scan(1'b0, 6'd0,    32'h0,         0);
      scan(1'b0, 6'd0,    32'h0,         0);
      scan(1'b0, 6'd0,    32'h0,         FL);

      // Randomized accesses biased toward decoded addresses and legal lengths.
      for (int t = 0; t < 60; t++) begin
         r = $urandom_range(0, 3);
         if (r < 2)       a = AW'($urandom_range(0, NR - 1));
         else if (r == 2) a = AW'(SB + $urandom_range(0, NS));
         else             a = AW'($urandom());
         r = $urandom_range(0, 9);
         ns = (r < 7) ? FL : (r == 7) ? FL - 1 : (r == 8) ? FL + 1 : 0;
         scan(1'($urandom_range(0, 1)), a, $urandom(), ns);
      end

      // Deselect mid-shift: tdo must drop and the shift register must hold.
      e = {m_rdata, m_last, m_err};
      cap_q.push_back(e);
      m_err = 1'b1;
      @(posedge drck_in); #2;
      capt_i = 1'b1;
      @(posedge drck_in); #2;
      capt_i = 1'b0;
      for (int i = 0; i < 5; i++) begin
         shift_i   = 1'b1;
         hub_tdi_i = 1'($urandom_range(0, 1));
         @(posedge drck_in); #2;
      end
      sel_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("desel_tdo", NR*DW'(hub_tdo_o), '0);
         @(posedge drck_in); #2;
      end
      shift_i = 1'b0;
      sel_i   = 1'b1;
      #1;
      check("desel_sr_hold", NR*DW'(hub_tdo_o), NR*DW'(e[5]));
      repeat (2) @(posedge drck_in);
      #2;
      scan(1'b0, 6'd0, 32'h0, FL);

      // Reset in the middle of a frame.
      model_scan(1'b0, 6'd0, 32'h0, 7);
      @(posedge drck_in); #2;
      capt_i = 1'b1;
      @(posedge drck_in); #2;
      capt_i = 1'b0;
      for (int i = 0; i < 20; i++) begin
         shift_i   = 1'b1;
         hub_tdi_i = 1'($urandom_range(0, 1));
         @(posedge drck_in); #2;
      end
      resetn_i = 1'b0;
      model_reset();
      #1;
      check("midreset_tdo", NR*DW'(hub_tdo_o), '0);
      check("midreset_wr_stb", NR*DW'(wr_stb_o), '0);
      check("midreset_wr_addr", NR*DW'(wr_addr_o), '0);
      check("midreset_cfg_regs", cfg_regs_o, '0);
      shift_i = 1'b0;
      repeat (2) @(posedge drck_in);
      #2;
      resetn_i = 1'b1;
      scan(1'b0, 6'd5, 32'h0, FL);
      scan(1'b0, 6'd0, 32'h0, FL);

      repeat (4) @(posedge drck_in);
      #2;
      check("cap_q_drained", NR*DW'(cap_q.size()), '0);
      check("wr_q_drained", NR*DW'(wr_q.size()), '0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
